// File: rtl/program_counter.sv
// Program counter: load/increment/hold with stall priority, updating on the falling edge of clock.
// Latency: one falling edge from load/inc to out; prev_out, wrap and misalign are registered alongside.
// Backpressure: stall freezes all state. Optional odd-target rejection under `PC_ALIGN_CHECK_EN.
module program_counter #(
  parameter int                 WIDTH        = 16,
  parameter logic [WIDTH-1:0]   RESET_VECTOR = '0,
  parameter int                 STEP         = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  input  logic             inc,
  input  logic             stall,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] prev_out,
  output logic             wrap,
  output logic             misalign
);

  localparam logic [WIDTH:0] STEP_EXT = (WIDTH+1)'(STEP);

  logic [WIDTH-1:0] pc_q, prev_q;
  logic [WIDTH-1:0] pc_d, prev_d;
  logic             wrap_q, wrap_d;
  logic             mis_d;
  logic [WIDTH:0]   sum;

  // Extra carry bit captures overflow past 2^WIDTH-1 for the wrap pulse.
  assign sum = {1'b0, pc_q} + STEP_EXT;

  always_comb begin
    pc_d   = pc_q;
    prev_d = prev_q;
    wrap_d = 1'b0;
    mis_d  = 1'b0;
    if (!stall) begin
      if (load) begin
`ifdef PC_ALIGN_CHECK_EN
        if (in[0]) begin
          mis_d = 1'b1;
        end else begin
          pc_d   = in;
          prev_d = pc_q;
        end
`else
        pc_d   = in;
        prev_d = pc_q;
`endif
      end else if (inc) begin
        pc_d   = sum[WIDTH-1:0];
        prev_d = pc_q;
        wrap_d = sum[WIDTH];
      end
    end
  end

  always_ff @(negedge clock or negedge reset) begin
    if (!reset) begin
      pc_q   <= RESET_VECTOR;
      prev_q <= RESET_VECTOR;
      wrap_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      prev_q <= prev_d;
      wrap_q <= wrap_d;
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  logic mis_q;

  always_ff @(negedge clock or negedge reset) begin
    if (!reset) begin
      mis_q <= 1'b0;
    end else begin
      mis_q <= mis_d;
    end
  end

  assign misalign = mis_q;
`else
  // Without the alignment check nothing can raise misalign.
  logic unused_mis;
  assign unused_mis = mis_d;
  assign misalign   = 1'b0;
`endif

  assign out      = pc_q;
  assign prev_out = prev_q;
  assign wrap     = wrap_q;

endmodule

// File: tb/tb_program_counter.sv
// Scoreboard bench for program_counter: driver queues expected state, monitor compares after each falling edge.
module tb_program_counter;

  typedef struct packed {
    logic [15:0] o;
    logic [15:0] p;
    logic        w;
    logic        m;
  } exp_t;

  logic        clock;
  logic        reset;
  logic [15:0] in;
  logic        load;
  logic        inc;
  logic        stall;
  logic [15:0] out;
  logic [15:0] prev_out;
  logic        wrap;
  logic        misalign;

  int vectors    = 0;
  int miscompares = 0;
  int vec_id     = 0;

  exp_t q[$];
  int   idq[$];

  program_counter #(
    .WIDTH        (16),
    .RESET_VECTOR (16'h0000),
    .STEP         (2)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .in       (in),
    .load     (load),
    .inc      (inc),
    .stall    (stall),
    .out      (out),
    .prev_out (prev_out),
    .wrap     (wrap),
    .misalign (misalign)
  );

  initial clock = 1'b0;
  always #10 clock = ~clock;

  task automatic check(input string name, input int id, input exp_t e);
    vectors++;
    if ({out, prev_out, wrap, misalign} !== e) begin
      miscompares++;
      $display("FAIL %s%0d: got out=%h prev=%h wrap=%b mis=%b, want out=%h prev=%h wrap=%b mis=%b",
               name, id, out, prev_out, wrap, misalign, e.o, e.p, e.w, e.m);
    end
  endtask

  // Drive one vector right after a rising edge; its effect is due at the following falling edge.
  task automatic vec(input logic l, input logic i, input logic s, input logic [15:0] d,
                     input logic [15:0] eo, input logic [15:0] ep, input logic ew, input logic em);
    exp_t e;
    @(posedge clock);
    #1;
    load  = l;
    inc   = i;
    stall = s;
    in    = d;
    e = '{o: eo, p: ep, w: ew, m: em};
    q.push_back(e);
    idq.push_back(vec_id);
    vec_id++;
  endtask

  task automatic drain();
    for (int k = 0; k < 4 && q.size() > 0; k++) begin
      @(negedge clock);
      #2;
    end
  endtask

  // Monitor
  initial begin
    exp_t e;
    int   id;
    forever begin
      @(negedge clock);
      #1;
      if (q.size() > 0) begin
        e  = q.pop_front();
        id = idq.pop_front();
        check("vec", id, e);
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t r;
    r = '{o: 16'h0000, p: 16'h0000, w: 1'b0, m: 1'b0};
    reset = 1'b0;
    load  = 1'b1;
    inc   = 1'b1;
    stall = 1'b0;
    in    = 16'h1234;

    #5;  check("reset_t5", 0, r);
    #16; check("reset_ignores_load", 0, r);
    #9;
    reset = 1'b1;
    load  = 1'b0;
    inc   = 1'b0;
    #5;  check("post_release_before_edge", 0, r);

    vec(1, 0, 0, 16'h0002, 16'h0002, 16'h0000, 0, 0);
    vec(1, 0, 0, 16'h0004, 16'h0004, 16'h0002, 0, 0);
    vec(1, 0, 0, 16'h0006, 16'h0006, 16'h0004, 0, 0);
    vec(1, 0, 0, 16'h000A, 16'h000A, 16'h0006, 0, 0);
    vec(1, 0, 0, 16'h000C, 16'h000C, 16'h000A, 0, 0);
    vec(1, 0, 0, 16'h000E, 16'h000E, 16'h000C, 0, 0);
    drain();

    // Asynchronous reset pulse while a load is pending.
    @(posedge clock);
    #1;
    load  = 1'b1;
    in    = 16'h000E;
    reset = 1'b0;
    #1;  check("async_reset", 0, r);
    #99; check("reset_held", 0, r);
    reset = 1'b1;
    load  = 1'b0;

    vec(1, 0, 0, 16'h0018, 16'h0018, 16'h0000, 0, 0);
    vec(1, 0, 0, 16'h001A, 16'h001A, 16'h0018, 0, 0);
    vec(1, 0, 0, 16'hFFFE, 16'hFFFE, 16'h001A, 0, 0);
    vec(0, 1, 0, 16'h0000, 16'h0000, 16'hFFFE, 1, 0);
    vec(0, 1, 0, 16'h0000, 16'h0002, 16'h0000, 0, 0);
    vec(0, 0, 0, 16'h0000, 16'h0002, 16'h0000, 0, 0);
    vec(0, 1, 0, 16'h0000, 16'h0004, 16'h0002, 0, 0);
    vec(1, 0, 1, 16'h1234, 16'h0004, 16'h0002, 0, 0);
    vec(0, 1, 1, 16'h1234, 16'h0004, 16'h0002, 0, 0);
    vec(1, 0, 0, 16'h1234, 16'h1234, 16'h0004, 0, 0);
    vec(1, 1, 0, 16'h0040, 16'h0040, 16'h1234, 0, 0);
    vec(1, 0, 0, 16'h0040, 16'h0040, 16'h0040, 0, 0);
`ifdef PC_ALIGN_CHECK_EN
    vec(1, 0, 0, 16'h0003, 16'h0040, 16'h0040, 0, 1);
    vec(0, 0, 0, 16'h0003, 16'h0040, 16'h0040, 0, 0);
    vec(0, 1, 0, 16'h0000, 16'h0042, 16'h0040, 0, 0);
`else
    vec(1, 0, 0, 16'h0003, 16'h0003, 16'h0040, 0, 0);
    vec(0, 0, 0, 16'h0003, 16'h0003, 16'h0040, 0, 0);
    vec(0, 1, 0, 16'h0000, 16'h0005, 16'h0003, 0, 0);
    vec(1, 0, 0, 16'hFFFF, 16'hFFFF, 16'h0005, 0, 0);
    vec(0, 1, 0, 16'h0000, 16'h0001, 16'hFFFF, 1, 0);
`endif
    vec(0, 0, 0, 16'h0000, (`ifdef PC_ALIGN_CHECK_EN 16'h0042 `else 16'h0001 `endif),
        (`ifdef PC_ALIGN_CHECK_EN 16'h0040 `else 16'hFFFF `endif), 0, 0);
    drain();

    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending entries, want 0", q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
